// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer, one slice evaluated per clock, LSB first
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             binvert,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SLT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             binv_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             set_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic             zero_q;

    logic             b2;
    logic             sum;
    logic             carry_d;
    logic             bit_d;
    logic             set_d;
    logic             ovf_d;
    logic [WIDTH-1:0] final_d;

    // Current slice always sits at bit 0 of the operand shift registers.
    always_comb begin
        b2      = binv_q ^ b_q[0];
        sum     = a_q[0] ^ b2 ^ carry_q;
        carry_d = (a_q[0] & b2) | (a_q[0] & carry_q) | (b2 & carry_q);
        bit_d   = 1'b0;
        case (op_q)
            OP_AND:  bit_d = a_q[0] & b_q[0];
            OP_OR:   bit_d = a_q[0] | b_q[0];
            OP_ADD:  bit_d = sum;
            default: bit_d = 1'b0;
        endcase
        set_d   = (a_q[0] != b2) ? sum : a_q[0];
        ovf_d   = (op_q == OP_ADD) && (a_q[0] == b2) && (sum != a_q[0]);
        final_d = result_q;
        if (op_q == OP_SLT) begin
            final_d = {{(WIDTH-1){1'b0}}, set_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_AND;
            binv_q     <= 1'b0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            set_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        binv_q  <= binvert;
                        carry_q <= binvert;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= carry_d;
                    result_q <= {bit_d, result_q[WIDTH-1:1]};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        set_q   <= set_d;
                        ovf_q   <= ovf_d;
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    result_q   <= final_d;
                    overflow_q <= ovf_q;
                    zero_q     <= (final_d == '0);
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
endmodule
